// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Buffered 8N1 UART transmitter; a small FIFO feeds an LSB-first
//            serialiser with back-to-back frames and a registered tx line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   send,
    input  logic [7:0]             data,
    output logic                   ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int c_BAUD_W       = (c_CLKS_PER_BIT > 1) ? $clog2(c_CLKS_PER_BIT) : 1;
    localparam int c_PTR_W        = $clog2(DEPTH);
    localparam int c_CNT_W        = c_PTR_W + 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [7:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [1:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                r_overflow;

    logic w_push;
    logic w_pop;
    logic w_bit_end;
    logic w_not_empty;

    // ready comes from the registered count only, so a same-cycle pop
    // never lets a full FIFO take another byte.
    assign ready       = (r_count != c_FULL);
    assign w_push      = send && ready;
    assign w_not_empty = (r_count != '0);
    assign w_bit_end   = (r_baud_cnt == c_BAUD_LAST);
    assign w_pop       = w_not_empty &&
                         ((r_state == c_ST_IDLE) || ((r_state == c_ST_STOP) && w_bit_end));

    assign tx       = r_tx;
    assign busy     = (r_state != c_ST_IDLE);
    assign count    = r_count;
    assign overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= send && !ready;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_tx       <= r_shift[0];
                        r_bit_idx  <= 3'd0;
                        r_state    <= c_ST_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        // Next start bit begins on the same edge the stop bit ends.
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_tx    <= 1'b0;
                            r_state <= c_ST_START;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_W'(1);
                    end
                end
                default: begin
                    r_baud_cnt <= '0;
                    r_tx       <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench for uart_tx_fifo against a frame-timeline
//            reference model and a mid-bit sampling line decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int DEF_CPB  = 50_000_000 / 115200;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       send  = 1'b0;
    logic [7:0] data  = 8'd0;
    logic       ready, tx, busy, overflow;
    logic [2:0] count;

    logic       send2 = 1'b0;
    logic [7:0] data2 = 8'd0;
    logic       ready2, tx2, busy2, overflow2;
    logic [2:0] count2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .send(send), .data(data), .ready(ready),
        .tx(tx), .busy(busy), .count(count), .overflow(overflow)
    );

    uart_tx_fifo dut_def (
        .clk(clk), .reset(reset), .send(send2), .data(data2), .ready(ready2),
        .tx(tx2), .busy(busy2), .count(count2), .overflow(overflow2)
    );

    // Reference model: byte queue plus the timeline of the frame on the line.
    logic [7:0] m_q[$];
    logic [7:0] m_popped[$];
    logic [7:0] m_byte;
    bit         m_active;
    bit         m_ovf;
    int         m_cyc;
    int         m_start;

    // Line decoder on the small DUT's tx.
    bit         rx_on;
    int         rx_t;
    logic [7:0] rx_byte;
    logic [7:0] rx_log[$];

    logic [6:0] exp_v;

    task automatic model_reset();
        m_q.delete();
        m_popped.delete();
        m_active = 1'b0;
        m_ovf    = 1'b0;
        rx_on    = 1'b0;
        rx_log.delete();
    endtask

    task automatic model_step();
        int sz0;
        sz0 = m_q.size();
        m_cyc++;
        m_ovf = send && (sz0 == DEPTH);
        if (m_active && (m_cyc == m_start + 10 * CPB)) m_active = 1'b0;
        if (!m_active && sz0 != 0) begin
            m_byte   = m_q.pop_front();
            m_start  = m_cyc;
            m_active = 1'b1;
            m_popped.push_back(m_byte);
        end
        if (send && sz0 < DEPTH) m_q.push_back(data);
    endtask

    function automatic logic m_tx();
        int k;
        if (!m_active) return 1'b1;
        k = (m_cyc - m_start) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [6:0] m_vec();
        return {m_tx(), m_active, (m_q.size() < DEPTH), m_ovf, 3'(m_q.size())};
    endfunction

    task automatic rx_step();
        int j;
        if (!rx_on && tx === 1'b0) begin
            rx_on = 1'b1;
            rx_t  = 0;
        end
        if (rx_on) begin
            if (rx_t % CPB == CPB / 2) begin
                j = rx_t / CPB;
                if (j >= 1 && j <= 8) rx_byte[j-1] = tx;
                if (j == 9) begin
                    rx_log.push_back(rx_byte);
                    rx_on = 1'b0;
                end
            end
            rx_t++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        rx_step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tx, busy, ready, overflow, count} !== 7'b1010000) begin
            n_fail++;
            $display("FAIL reset_state {tx,busy,ready,ovf,count} got=%b want=1010000",
                     {tx, busy, ready, overflow, count});
        end
        n_checks++;
        if ({tx2, busy2, ready2, overflow2, count2} !== 7'b1010000) begin
            n_fail++;
            $display("FAIL reset_state_default got=%b want=1010000",
                     {tx2, busy2, ready2, overflow2, count2});
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_v = m_vec();
            n_checks++;
            if ({tx, busy, ready, overflow, count} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", m_cyc,
                         {tx, busy, ready, overflow, count}, exp_v);
            end
        end
    endtask

    task automatic test_single_byte();
        int busy_cnt;
        busy_cnt = 0;
        rx_log.delete();
        for (int i = 0; i < 110; i++) begin
            send = (i == 0);
            data = 8'h41;
            tick();
            if (busy === 1'b1) busy_cnt++;
            exp_v = m_vec();
            n_checks++;
            if ({tx, busy, ready, overflow, count} !== exp_v) begin
                n_fail++;
                $display("FAIL single_byte cyc=%0d got=%b want=%b", m_cyc,
                         {tx, busy, ready, overflow, count}, exp_v);
            end
        end
        send = 1'b0;
        n_checks++;
        if (busy_cnt != 10 * CPB) begin
            n_fail++;
            $display("FAIL single_byte_busy_cycles got=%0d want=%0d", busy_cnt, 10 * CPB);
        end
        n_checks++;
        if (rx_log.size() != 1 || rx_log[0] !== 8'h41) begin
            n_fail++;
            $display("FAIL single_byte_decoded frames=%0d first=%h want 1 frame of 41",
                     rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : 8'hxx);
        end
    endtask

    task automatic test_burst_overflow();
        int ovf_cnt;
        ovf_cnt = 0;
        rx_log.delete();
        for (int i = 0; i < 530; i++) begin
            send = (i < 6);
            data = 8'(8'h41 + i);
            tick();
            if (overflow === 1'b1) ovf_cnt++;
            exp_v = m_vec();
            n_checks++;
            if ({tx, busy, ready, overflow, count} !== exp_v) begin
                n_fail++;
                $display("FAIL burst cyc=%0d got=%b want=%b", m_cyc,
                         {tx, busy, ready, overflow, count}, exp_v);
            end
        end
        send = 1'b0;
        n_checks++;
        if (ovf_cnt != 1) begin
            n_fail++;
            $display("FAIL burst_overflow_pulses got=%0d want=1", ovf_cnt);
        end
        n_checks++;
        if (rx_log.size() != 5) begin
            n_fail++;
            $display("FAIL burst_frame_count got=%0d want=5", rx_log.size());
        end
        for (int k = 0; k < 5 && k < rx_log.size(); k++) begin
            n_checks++;
            if (rx_log[k] !== 8'(8'h41 + k)) begin
                n_fail++;
                $display("FAIL burst_frame[%0d] got=%h want=%h", k, rx_log[k], 8'(8'h41 + k));
            end
        end
    endtask

    task automatic test_push_on_pop();
        int hits;
        bit hit_now;
        hits = 0;
        rx_log.delete();
        m_popped.delete();
        for (int i = 0; i < 700; i++) begin
            hit_now = (i >= 5) && m_active && (m_cyc + 1 == m_start + 10 * CPB) && (hits < 2);
            send = (i < 5) || hit_now;
            data = 8'($urandom);
            if (hit_now) hits++;
            tick();
            exp_v = m_vec();
            n_checks++;
            if ({tx, busy, ready, overflow, count} !== exp_v) begin
                n_fail++;
                $display("FAIL push_on_pop cyc=%0d got=%b want=%b", m_cyc,
                         {tx, busy, ready, overflow, count}, exp_v);
            end
            if (hit_now) begin
                n_checks++;
                if ({overflow, count} !== ((hits == 1) ? 4'b1011 : 4'b0011)) begin
                    n_fail++;
                    $display("FAIL push_on_pop_edge%0d {ovf,count} got=%b want=%b", hits,
                             {overflow, count}, (hits == 1) ? 4'b1011 : 4'b0011);
                end
            end
        end
        send = 1'b0;
        n_checks++;
        if (hits != 2 || rx_log.size() != m_popped.size() || rx_log.size() != 6) begin
            n_fail++;
            $display("FAIL push_on_pop_frames edges=%0d decoded=%0d want edges=2 decoded=6",
                     hits, rx_log.size());
        end
        for (int k = 0; k < rx_log.size() && k < m_popped.size(); k++) begin
            n_checks++;
            if (rx_log[k] !== m_popped[k]) begin
                n_fail++;
                $display("FAIL push_on_pop_frame[%0d] got=%h want=%h", k, rx_log[k], m_popped[k]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            send = (i < 3);
            data = (i == 0) ? 8'h55 : 8'($urandom);
            tick();
            exp_v = m_vec();
            n_checks++;
            if ({tx, busy, ready, overflow, count} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc=%0d got=%b want=%b", m_cyc,
                         {tx, busy, ready, overflow, count}, exp_v);
            end
            if (m_active && m_cyc == m_start + 4 * CPB + 3) hit = 1'b1;
        end
        send = 1'b0;
        n_checks++;
        if (!hit || count !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_mid_setup reached=%0d count got=%0d want=2", hit, count);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({tx, busy, count, ready} !== 6'b100001) begin
            n_fail++;
            $display("FAIL reset_mid_async {tx,busy,count,ready} got=%b want=100001",
                     {tx, busy, count, ready});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            exp_v = m_vec();
            n_checks++;
            if ({tx, busy, ready, overflow, count} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_after cyc=%0d got=%b want=%b", m_cyc,
                         {tx, busy, ready, overflow, count}, exp_v);
            end
        end
        n_checks++;
        if (rx_log.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_frame got=%0d frames want=0", rx_log.size());
        end
    endtask

    task automatic test_wrap();
        int n_pushed;
        n_pushed = 0;
        rx_log.delete();
        for (int i = 0; i < 1100; i++) begin
            send = (n_pushed < 9) && (m_q.size() < 3);
            data = 8'(n_pushed);
            tick();
            if (send) n_pushed++;
            exp_v = m_vec();
            n_checks++;
            if ({tx, busy, ready, overflow, count} !== exp_v) begin
                n_fail++;
                $display("FAIL wrap cyc=%0d got=%b want=%b", m_cyc,
                         {tx, busy, ready, overflow, count}, exp_v);
            end
        end
        send = 1'b0;
        n_checks++;
        if (rx_log.size() != 9) begin
            n_fail++;
            $display("FAIL wrap_frame_count got=%0d want=9", rx_log.size());
        end
        for (int k = 0; k < 9 && k < rx_log.size(); k++) begin
            n_checks++;
            if (rx_log[k] !== 8'(k)) begin
                n_fail++;
                $display("FAIL wrap_frame[%0d] got=%h want=%h", k, rx_log[k], 8'(k));
            end
        end
    endtask

    task automatic test_random();
        rx_log.delete();
        m_popped.delete();
        for (int i = 0; i < 2000; i++) begin
            send = (i < 1400) && ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            tick();
            exp_v = m_vec();
            n_checks++;
            if ({tx, busy, ready, overflow, count} !== exp_v) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b want=%b", m_cyc,
                         {tx, busy, ready, overflow, count}, exp_v);
            end
        end
        send = 1'b0;
        n_checks++;
        if (rx_log.size() != m_popped.size() || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain decoded=%0d busy=%b want decoded=%0d busy=0",
                     rx_log.size(), busy, m_popped.size());
        end
        for (int k = 0; k < rx_log.size() && k < m_popped.size(); k++) begin
            n_checks++;
            if (rx_log[k] !== m_popped[k]) begin
                n_fail++;
                $display("FAIL random_frame[%0d] got=%h want=%h", k, rx_log[k], m_popped[k]);
            end
        end
    endtask

    task automatic test_default_params();
        int low_cnt;
        int busy_cnt;
        int first_low;
        low_cnt   = 0;
        busy_cnt  = 0;
        first_low = -1;
        send = 1'b0;
        for (int i = 0; i < 4400; i++) begin
            send2 = (i == 0);
            data2 = 8'hFF;
            tick();
            if (tx2 === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = i;
            end
            if (busy2 === 1'b1) busy_cnt++;
        end
        send2 = 1'b0;
        n_checks++;
        if (first_low != 1) begin
            n_fail++;
            $display("FAIL default_latency first start-bit sample got=%0d want=1", first_low);
        end
        n_checks++;
        if (low_cnt != DEF_CPB) begin
            n_fail++;
            $display("FAIL default_start_bit got=%0d cycles want=%0d", low_cnt, DEF_CPB);
        end
        n_checks++;
        if (busy_cnt != 10 * DEF_CPB) begin
            n_fail++;
            $display("FAIL default_frame got=%0d cycles want=%0d", busy_cnt, 10 * DEF_CPB);
        end
        n_checks++;
        if ({tx2, busy2, ready2, count2} !== 6'b101000) begin
            n_fail++;
            $display("FAIL default_end_state {tx,busy,ready,count} got=%b want=101000",
                     {tx2, busy2, ready2, count2});
        end
    endtask

    initial begin
        m_cyc = 0;
        m_start = 0;
        test_reset();
        test_single_byte();
        test_burst_overflow();
        test_push_on_pop();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        test_default_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
